adc_wave_meas: RTL and testbench

ADC_WAVE_MEAS -- requirements
Module: adc_wave_meas

---
 rtl/adc_wave_meas_pkg.sv | 17 +
 rtl/adc_wave_meas_clk_gen.sv | 45 ++++
 rtl/adc_wave_meas.sv | 210 +++++++++++++++++++++
 tb/tb_adc_wave_meas.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_wave_meas_pkg.sv
// Shared definitions for the ADC waveform measurement block.
//   state_e : measurement FSM states
//   XCNT_W  : width of the rising-crossing count result
//   SPAN_W  : width of the crossing-span result (sys_clk cycles)
package adc_wave_meas_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_MEAS = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int unsigned XCNT_W = 16;
  localparam int unsigned SPAN_W = 32;

endpackage

// File: rtl/adc_wave_meas_clk_gen.sv
// ADC sample-clock divider and sample-strobe generator.
//   clk_i    : system clock
//   rst_i    : synchronous active-high reset
//   ad_clk_o : 50% duty ADC clock, low for CLK_DIV/2 cycles then high for CLK_DIV/2
//   strobe_o : high for the one sys_clk cycle in which ad_clk_o has just risen
module adc_clk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic ad_clk_o,
  output logic strobe_o
);

  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HALF  = CLK_DIV / 2;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ad_clk_q, ad_clk_d;
  logic             strobe_q, strobe_d;

  // ad_clk and strobe are registered from the next divider value so both
  // change on the same edge and are glitch-free.
  always_comb begin
    cnt_d    = (cnt_q == CNT_W'(CLK_DIV - 1)) ? '0 : cnt_q + 1'b1;
    ad_clk_d = (cnt_d >= CNT_W'(HALF));
    strobe_d = (cnt_d == CNT_W'(HALF));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      ad_clk_q <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ad_clk_q <= ad_clk_d;
      strobe_q <= strobe_d;
    end
  end

  assign ad_clk_o = ad_clk_q;
  assign strobe_o = strobe_q;

endmodule

// File: rtl/adc_wave_meas.sv
// ADC waveform measurement: over one window of WIN_LEN samples, reports
// min/max/peak-to-peak, count of rising mid-level crossings (with hysteresis),
// sys_clk span between first and last crossing, and an out-of-range flag.
//   sys_clk, sys_rst       : clock, synchronous active-high reset
//   ad_clk                 : generated ADC sample clock
//   ad_data, ad_otr        : ADC sample and out-of-range flag
//   start, busy            : window request pulse / window armed-or-measuring
//   res_valid, res_ack     : result handshake
//   res_min/max/vpp/xcnt/span/otr : window results
module adc_wave_meas
  import adc_wave_meas_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned WIN_LEN = 1024,
  parameter int unsigned HYST    = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  output logic              ad_clk,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              ad_otr,
  input  logic              start,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ack,
  output logic [DATA_W-1:0] res_min,
  output logic [DATA_W-1:0] res_max,
  output logic [DATA_W-1:0] res_vpp,
  output logic [XCNT_W-1:0] res_xcnt,
  output logic [SPAN_W-1:0] res_span,
  output logic              res_otr
);

  localparam int unsigned SCNT_W = $clog2(WIN_LEN + 1);
  localparam logic [DATA_W:0] HYST_W = (DATA_W + 1)'(HYST);
  localparam logic [DATA_W:0] MAX_W  = {1'b0, {DATA_W{1'b1}}};

  logic strobe;

  adc_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .ad_clk_o(ad_clk),
    .strobe_o(strobe)
  );

  state_e            state_q, state_d;
  logic [DATA_W-1:0] min_q, min_d, max_q, max_d;
  logic              otr_q, otr_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [XCNT_W-1:0] xcnt_q, xcnt_d;
  logic              armed_q, armed_d;
  logic              first_q, first_d;
  logic [SPAN_W-1:0] span_cnt_q, span_cnt_d;
  logic [SPAN_W-1:0] span_last_q, span_last_d;

  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_min_q, res_min_d, res_max_q, res_max_d, res_vpp_q, res_vpp_d;
  logic [XCNT_W-1:0] res_xcnt_q, res_xcnt_d;
  logic [SPAN_W-1:0] res_span_q, res_span_d;
  logic              res_otr_q, res_otr_d;

  // Per-sample datapath: running extremes including the current sample,
  // mid-level and saturated hysteresis thresholds.
  logic [DATA_W-1:0] min_upd, max_upd;
  logic [DATA_W:0]   smp_w, mid_w, lo_thr, hi_sum, hi_thr;
  logic [SPAN_W-1:0] span_inc;

  always_comb begin
    min_upd  = (ad_data < min_q) ? ad_data : min_q;
    max_upd  = (ad_data > max_q) ? ad_data : max_q;
    smp_w    = {1'b0, ad_data};
    mid_w    = ({1'b0, min_upd} + {1'b0, max_upd}) >> 1;
    lo_thr   = (mid_w > HYST_W) ? (mid_w - HYST_W) : '0;
    hi_sum   = mid_w + HYST_W;
    hi_thr   = (hi_sum > MAX_W) ? MAX_W : hi_sum;
    span_inc = (span_cnt_q == '1) ? span_cnt_q : span_cnt_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    min_d       = min_q;
    max_d       = max_q;
    otr_d       = otr_q;
    scnt_d      = scnt_q;
    xcnt_d      = xcnt_q;
    armed_d     = armed_q;
    first_d     = first_q;
    span_cnt_d  = span_cnt_q;
    span_last_d = span_last_q;
    res_valid_d = res_valid_q;
    res_min_d   = res_min_q;
    res_max_d   = res_max_q;
    res_vpp_d   = res_vpp_q;
    res_xcnt_d  = res_xcnt_q;
    res_span_d  = res_span_q;
    res_otr_d   = res_otr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ARM;
      end
      S_ARM: begin
        if (strobe) begin
          state_d     = S_MEAS;
          min_d       = '1;
          max_d       = '0;
          otr_d       = 1'b0;
          scnt_d      = '0;
          xcnt_d      = '0;
          armed_d     = 1'b0;
          first_d     = 1'b0;
          span_cnt_d  = '0;
          span_last_d = '0;
        end
      end
      S_MEAS: begin
        // Span counter runs every sys_clk once the first crossing is seen.
        if (first_q) span_cnt_d = span_inc;
        if (strobe) begin
          min_d  = min_upd;
          max_d  = max_upd;
          otr_d  = otr_q | ad_otr;
          scnt_d = scnt_q + 1'b1;
          if (armed_q && (smp_w > hi_thr)) begin
            armed_d = 1'b0;
            if (xcnt_q != '1) xcnt_d = xcnt_q + 1'b1;
            if (!first_q) begin
              first_d    = 1'b1;
              span_cnt_d = '0;
            end else begin
              span_last_d = span_inc;
            end
          end else if (smp_w < lo_thr) begin
            armed_d = 1'b1;
          end
          if (scnt_q == SCNT_W'(WIN_LEN - 1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
          res_min_d   = min_q;
          res_max_d   = max_q;
          res_vpp_d   = max_q - min_q;
          res_xcnt_d  = xcnt_q;
          res_span_d  = span_last_q;
          res_otr_d   = otr_q;
        end else if (res_ack) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      min_q       <= '0;
      max_q       <= '0;
      otr_q       <= 1'b0;
      scnt_q      <= '0;
      xcnt_q      <= '0;
      armed_q     <= 1'b0;
      first_q     <= 1'b0;
      span_cnt_q  <= '0;
      span_last_q <= '0;
      res_valid_q <= 1'b0;
      res_min_q   <= '0;
      res_max_q   <= '0;
      res_vpp_q   <= '0;
      res_xcnt_q  <= '0;
      res_span_q  <= '0;
      res_otr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      max_q       <= max_d;
      otr_q       <= otr_d;
      scnt_q      <= scnt_d;
      xcnt_q      <= xcnt_d;
      armed_q     <= armed_d;
      first_q     <= first_d;
      span_cnt_q  <= span_cnt_d;
      span_last_q <= span_last_d;
      res_valid_q <= res_valid_d;
      res_min_q   <= res_min_d;
      res_max_q   <= res_max_d;
      res_vpp_q   <= res_vpp_d;
      res_xcnt_q  <= res_xcnt_d;
      res_span_q  <= res_span_d;
      res_otr_q   <= res_otr_d;
    end
  end

  assign busy      = (state_q == S_ARM) || (state_q == S_MEAS);
  assign res_valid = res_valid_q;
  assign res_min   = res_min_q;
  assign res_max   = res_max_q;
  assign res_vpp   = res_vpp_q;
  assign res_xcnt  = res_xcnt_q;
  assign res_span  = res_span_q;
  assign res_otr   = res_otr_q;

endmodule

// File: tb/tb_adc_wave_meas.sv
// Bench for adc_wave_meas: instance A (WIN_LEN=16) and instance B (WIN_LEN=64)
// share clock, reset and ADC inputs; expected results are queued at window
// start and checked by a monitor when res_valid rises.
module tb_adc_wave_meas;

  typedef struct {
    logic [7:0]  mn;
    logic [7:0]  mx;
    logic [7:0]  vpp;
    logic [15:0] xc;
    logic [31:0] sp;
    logic        ot;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [7:0]  ad_data = 8'h00;
  logic        ad_otr  = 1'b0;
  logic        start_a = 1'b0, ack_a = 1'b0, start_b = 1'b0, ack_b = 1'b0;

  logic        ad_clk_a, busy_a, valid_a, otr_a;
  logic [7:0]  min_a, max_a, vpp_a;
  logic [15:0] xcnt_a;
  logic [31:0] span_a;
  logic        ad_clk_b, busy_b, valid_b, otr_b;
  logic [7:0]  min_b, max_b, vpp_b;
  logic [15:0] xcnt_b;
  logic [31:0] span_b;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 sys_clk = ~sys_clk;

  adc_wave_meas #(.DATA_W(8), .CLK_DIV(2), .WIN_LEN(16), .HYST(4)) u_dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ad_clk(ad_clk_a),
    .ad_data(ad_data), .ad_otr(ad_otr), .start(start_a), .busy(busy_a),
    .res_valid(valid_a), .res_ack(ack_a), .res_min(min_a), .res_max(max_a),
    .res_vpp(vpp_a), .res_xcnt(xcnt_a), .res_span(span_a), .res_otr(otr_a)
  );

  adc_wave_meas #(.DATA_W(8), .CLK_DIV(2), .WIN_LEN(64), .HYST(4)) u_dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ad_clk(ad_clk_b),
    .ad_data(ad_data), .ad_otr(ad_otr), .start(start_b), .busy(busy_b),
    .res_valid(valid_b), .res_ack(ack_b), .res_min(min_b), .res_max(max_b),
    .res_vpp(vpp_b), .res_xcnt(xcnt_b), .res_span(span_b), .res_otr(otr_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic cmp_res(input string p, input exp_t e, input logic [7:0] mn, input logic [7:0] mx,
                         input logic [7:0] vp, input logic [15:0] xc, input logic [31:0] sp,
                         input logic ot);
    chk({p, "_min"},  32'(mn), 32'(e.mn));
    chk({p, "_max"},  32'(mx), 32'(e.mx));
    chk({p, "_vpp"},  32'(vp), 32'(e.vpp));
    chk({p, "_xcnt"}, 32'(xc), 32'(e.xc));
    chk({p, "_span"}, sp,      e.sp);
    chk({p, "_otr"},  32'(ot), 32'(e.ot));
  endtask

  // Advance to the next negedge inside a strobe cycle (ad_clk high).
  task automatic next_strobe();
    int unsigned n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (ad_clk_a !== 1'b1 && n < 4);
    if (ad_clk_a !== 1'b1) chk("strobe_timeout", 32'(ad_clk_a), 32'd1);
  endtask

  // Pulse start in a non-strobe cycle so that ARM consumes the following strobe.
  task automatic pulse_start(input bit on_b);
    int unsigned n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (ad_clk_a !== 1'b0 && n < 4);
    if (on_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge sys_clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic feed(input logic [7:0] smp[$], input int otr_at, input bit on_b);
    foreach (smp[i]) begin
      next_strobe();
      ad_data = smp[i];
      ad_otr  = (i == otr_at);
      if (i == 0) chk("busy_meas", 32'(on_b ? busy_b : busy_a), 32'd1);
    end
  endtask

  task automatic run_window(input bit on_b, input logic [7:0] smp[$], input int otr_at,
                            input exp_t e);
    if (on_b) qb.push_back(e); else qa.push_back(e);
    pulse_start(on_b);
    feed(smp, otr_at, on_b);
    @(negedge sys_clk);
    ad_otr = 1'b0;
    chk("valid_early", 32'(on_b ? valid_b : valid_a), 32'd0);
    chk("busy_done",   32'(on_b ? busy_b : busy_a), 32'd0);
    @(negedge sys_clk);
    chk("valid_latency", 32'(on_b ? valid_b : valid_a), 32'd1);
  endtask

  task automatic do_ack(input bit on_b);
    if (on_b) ack_b = 1'b1; else ack_a = 1'b1;
    @(negedge sys_clk);
    ack_a = 1'b0;
    ack_b = 1'b0;
    chk("valid_after_ack", 32'(on_b ? valid_b : valid_a), 32'd0);
    chk("busy_after_ack",  32'(on_b ? busy_b : busy_a), 32'd0);
  endtask

  task automatic chk_zero_a(input string p);
    chk({p, "_adclk"}, 32'(ad_clk_a), 32'd0);
    chk({p, "_busy"},  32'(busy_a),   32'd0);
    chk({p, "_valid"}, 32'(valid_a),  32'd0);
    cmp_res(p, '{8'h00, 8'h00, 8'h00, 16'h0, 32'h0, 1'b0},
            min_a, max_a, vpp_a, xcnt_a, span_a, otr_a);
  endtask

  initial begin
    logic [7:0] smp[$];
    exp_t       e;

    // Scoreboard monitor: compare on each rising edge of res_valid.
    fork
      begin
        logic pa = 1'b0, pb = 1'b0;
        forever begin
          @(negedge sys_clk);
          if (valid_a && !pa) begin
            if (qa.size() == 0) chk("a_unexpected_result", 32'd1, 32'd0);
            else cmp_res("a", qa.pop_front(), min_a, max_a, vpp_a, xcnt_a, span_a, otr_a);
          end
          if (valid_b && !pb) begin
            if (qb.size() == 0) chk("b_unexpected_result", 32'd1, 32'd0);
            else cmp_res("b", qb.pop_front(), min_b, max_b, vpp_b, xcnt_b, span_b, otr_b);
          end
          pa = valid_a;
          pb = valid_b;
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk_zero_a("rst");
    sys_rst = 1'b0;

    // Constant mid-scale input
    smp = {};
    for (int i = 0; i < 16; i++) smp.push_back(8'h80);
    run_window(1'b0, smp, -1, '{8'h80, 8'h80, 8'h00, 16'd0, 32'd0, 1'b0});
    do_ack(1'b0);

    // +/-2 LSB noise around 0x80: inside hysteresis, no crossings
    smp = {8'h7E, 8'h82, 8'h80, 8'h7F, 8'h81, 8'h7E, 8'h82, 8'h80,
           8'h7F, 8'h81, 8'h7E, 8'h82, 8'h80, 8'h7F, 8'h81, 8'h80};
    run_window(1'b0, smp, -1, '{8'h7E, 8'h82, 8'h04, 16'd0, 32'd0, 1'b0});
    do_ack(1'b0);

    // Out-of-range on a single sample, then start in DONE without ack
    smp = {};
    for (int i = 0; i < 16; i++) smp.push_back(8'h50);
    e = '{8'h50, 8'h50, 8'h00, 16'd0, 32'd0, 1'b1};
    run_window(1'b0, smp, 5, e);
    for (int k = 0; k < 3; k++) begin
      start_a = 1'b1;
      @(negedge sys_clk);
      start_a = 1'b0;
      @(negedge sys_clk);
      chk("done_start_busy",  32'(busy_a),  32'd0);
      chk("done_start_valid", 32'(valid_a), 32'd1);
      chk("done_hold_min",    32'(min_a),   32'(e.mn));
      chk("done_hold_otr",    32'(otr_a),   32'(e.ot));
    end
    do_ack(1'b0);

    // Ramp, no out-of-range: otr flag must be cleared for the new window
    smp = {};
    for (int i = 0; i < 16; i++) smp.push_back(8'(8'h10 + 8 * i));
    run_window(1'b0, smp, -1, '{8'h10, 8'h88, 8'h78, 16'd0, 32'd0, 1'b0});
    do_ack(1'b0);

    // Low-end threshold saturation: mid 4 - HYST clamps at 0, never arms
    smp = {};
    for (int i = 0; i < 16; i++) smp.push_back((i % 2 == 0) ? 8'h00 : 8'h09);
    run_window(1'b0, smp, -1, '{8'h00, 8'h09, 8'h09, 16'd0, 32'd0, 1'b0});
    do_ack(1'b0);

    // Square wave 0x20/0xE0, 8-sample period, 64 samples: crossings at
    // samples 12,20,...,60 -> 7 crossings, span 6 periods * 16 cycles = 96
    smp = {};
    for (int i = 0; i < 64; i++) smp.push_back(((i / 4) % 2 == 0) ? 8'h20 : 8'hE0);
    run_window(1'b1, smp, -1, '{8'h20, 8'hE0, 8'hC0, 16'd7, 32'd96, 1'b0});
    do_ack(1'b1);

    // Reset in the middle of a measurement window
    smp = {8'h11, 8'hF0, 8'h22, 8'hE0, 8'h33};
    pulse_start(1'b0);
    feed(smp, 2, 1'b0);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk_zero_a("midrst");
    sys_rst = 1'b0;
    ad_otr  = 1'b0;
    repeat (20) @(negedge sys_clk);
    chk("midrst_no_valid", 32'(valid_a), 32'd0);

    smp = {};
    for (int i = 0; i < 16; i++) smp.push_back(8'h33);
    run_window(1'b0, smp, -1, '{8'h33, 8'h33, 8'h00, 16'd0, 32'd0, 1'b0});
    do_ack(1'b0);

    repeat (4) @(negedge sys_clk);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
